// File: rtl/memory_stage_if.sv
// Bundle of the memory stage's upstream, downstream and data-memory handshake signals.
// The stage uses the slave modport; the surrounding pipeline/memory uses master.
interface memory_stage_if;
    // Upstream (execute) side
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_icode;
    logic        in_Cnd;
    logic [31:0] in_valE;
    logic [31:0] in_valA;
    logic [31:0] in_valP;
    logic [3:0]  in_dstE;
    logic [3:0]  in_dstM;
    logic [2:0]  in_stat;
    // Downstream (write-back) side
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_icode;
    logic [31:0] out_valE;
    logic [31:0] out_valM;
    logic [3:0]  out_dstE;
    logic [3:0]  out_dstM;
    logic [2:0]  out_stat;
    // Data memory port
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport slave (
        input  in_valid, in_icode, in_Cnd, in_valE, in_valA, in_valP, in_dstE, in_dstM, in_stat,
        output in_ready,
        output out_valid, out_icode, out_valE, out_valM, out_dstE, out_dstM, out_stat,
        input  out_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata, mem_err
    );

    modport master (
        output in_valid, in_icode, in_Cnd, in_valE, in_valA, in_valP, in_dstE, in_dstM, in_stat,
        input  in_ready,
        input  out_valid, out_icode, out_valE, out_valM, out_dstE, out_dstM, out_stat,
        output out_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata, mem_err
    );
endinterface

// File: rtl/memory_stage.sv
// Y86 memory stage: one data access per instruction over a req/ack port, with fault and
// timeout conversion to ADR and a sticky halt once a non-AOK status has been emitted.
module memory_stage #(
    parameter int unsigned MEM_SIZE = 4096,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    memory_stage_if.slave bus,
    output logic          halted
);
    localparam int unsigned CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0] MaxAddr = 32'(MEM_SIZE - 4);
    localparam logic [2:0]  StatAok = 3'd1;
    localparam logic [2:0]  StatAdr = 3'd3;

    typedef enum logic [1:0] {StIdle, StAccess, StOut, StHalt} state_e;

    state_e          state_q, state_d;
    logic [3:0]      icode_q, icode_d;
    logic [31:0]     vale_q, vale_d;
    logic [31:0]     valm_q, valm_d;
    logic [3:0]      dste_q, dste_d;
    logic [3:0]      dstm_q, dstm_d;
    logic [2:0]      stat_q, stat_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            halted_q, halted_d;

    logic            acc;
    logic            acc_we;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_wdata;

    always_comb begin
        acc       = 1'b0;
        acc_we    = 1'b0;
        acc_addr  = bus.in_valE;
        acc_wdata = bus.in_valA;
        case (bus.in_icode)
            4'h4, 4'hA: begin acc = 1'b1; acc_we = 1'b1; end
            4'h5:       acc = 1'b1;
            4'h8:       begin acc = 1'b1; acc_we = 1'b1; acc_wdata = bus.in_valP; end
            4'h9, 4'hB: begin acc = 1'b1; acc_addr = bus.in_valA; end
            default:    ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        icode_d  = icode_q;
        vale_d   = vale_q;
        valm_d   = valm_q;
        dste_d   = dste_q;
        dstm_d   = dstm_q;
        stat_d   = stat_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        halted_d = halted_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    icode_d = bus.in_icode;
                    vale_d  = bus.in_valE;
                    valm_d  = '0;
                    dste_d  = (bus.in_icode == 4'h2 && !bus.in_Cnd) ? 4'hF : bus.in_dstE;
                    dstm_d  = bus.in_dstM;
                    stat_d  = bus.in_stat;
                    state_d = StOut;
                    if (bus.in_stat == StatAok && acc) begin
                        // Unsigned compare also rejects addresses that would wrap past 2^32.
                        if (acc_addr > MaxAddr) begin
                            stat_d = StatAdr;
                        end else begin
                            req_d   = 1'b1;
                            we_d    = acc_we;
                            addr_d  = acc_addr;
                            wdata_d = acc_wdata;
                            cnt_d   = '0;
                            state_d = StAccess;
                        end
                    end
                end
            end
            StAccess: begin
                // An ack arriving on the final timeout cycle still completes the access.
                if (bus.mem_ack) begin
                    req_d   = 1'b0;
                    state_d = StOut;
                    if (bus.mem_err) begin
                        stat_d = StatAdr;
                        valm_d = '0;
                    end else if (!we_q) begin
                        valm_d = bus.mem_rdata;
                    end
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    stat_d  = StatAdr;
                    state_d = StOut;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StOut: begin
                if (bus.out_ready) begin
                    if (stat_q == StatAok) begin
                        state_d = StIdle;
                    end else begin
                        state_d  = StHalt;
                        halted_d = 1'b1;
                    end
                end
            end
            StHalt:  ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            icode_q  <= '0;
            vale_q   <= '0;
            valm_q   <= '0;
            dste_q   <= 4'hF;
            dstm_q   <= 4'hF;
            stat_q   <= StatAok;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            icode_q  <= icode_d;
            vale_q   <= vale_d;
            valm_q   <= valm_d;
            dste_q   <= dste_d;
            dstm_q   <= dstm_d;
            stat_q   <= stat_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StOut);
    assign bus.out_icode = icode_q;
    assign bus.out_valE  = vale_q;
    assign bus.out_valM  = valm_q;
    assign bus.out_dstE  = dste_q;
    assign bus.out_dstM  = dstm_q;
    assign bus.out_stat  = stat_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign halted        = halted_q;
endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: vector table with a result scoreboard, a memory
// responder with programmable ack timing, and hand-written reset/halt sequences.
module tb_memory_stage;
    logic clock = 1'b0;
    logic reset_n;
    logic halted;

    memory_stage_if bus ();

    memory_stage #(
        .MEM_SIZE(4096),
        .TIMEOUT (16)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus),
        .halted (halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  icode;
        logic        cnd;
        logic [31:0] vale, vala, valp;
        logic [3:0]  dste, dstm;
        logic [2:0]  stat;
        int          ack_at;   // ack during this request cycle (0 = never)
        logic [31:0] rdata;
        logic        err;
        int          hold;     // cycles out_ready stays low once out_valid is seen
        logic        late_ack; // drive a stray ack while the result is held
        int          x_req;    // expected number of cycles with mem_req high
        logic        x_we;
        logic [31:0] x_addr, x_wdata, x_valm;
        logic [3:0]  x_dste;
        logic [2:0]  x_stat;
    } vec_t;

    typedef struct {
        logic [3:0]  icode;
        logic [31:0] vale, valm;
        logic [3:0]  dste, dstm;
        logic [2:0]  stat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic [3:0] icode, input logic cnd, input logic [31:0] vale, input logic [31:0] vala,
        input logic [31:0] valp, input logic [3:0] dste, input logic [3:0] dstm,
        input logic [2:0] stat, input int ack_at, input logic [31:0] rdata, input logic err,
        input int hold, input logic late_ack, input int x_req, input logic x_we,
        input logic [31:0] x_addr, input logic [31:0] x_wdata, input logic [31:0] x_valm,
        input logic [3:0] x_dste, input logic [2:0] x_stat);
        vec_t v;
        v.icode = icode; v.cnd = cnd; v.vale = vale; v.vala = vala; v.valp = valp;
        v.dste = dste; v.dstm = dstm; v.stat = stat; v.ack_at = ack_at; v.rdata = rdata;
        v.err = err; v.hold = hold; v.late_ack = late_ack; v.x_req = x_req; v.x_we = x_we;
        v.x_addr = x_addr; v.x_wdata = x_wdata; v.x_valm = x_valm; v.x_dste = x_dste;
        v.x_stat = x_stat;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_icode  = 4'h1;
        bus.in_Cnd    = 1'b0;
        bus.in_valE   = '0;
        bus.in_valA   = '0;
        bus.in_valP   = '0;
        bus.in_dstE   = 4'hF;
        bus.in_dstM   = 4'hF;
        bus.in_stat   = 3'd1;
        bus.out_ready = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_err   = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clock);
        check("rst in_ready", 32'(bus.in_ready), 1);
        check("rst out_valid", 32'(bus.out_valid), 0);
        check("rst mem_req", 32'(bus.mem_req), 0);
        check("rst mem_we", 32'(bus.mem_we), 0);
        check("rst halted", 32'(halted), 0);
        check("rst mem_addr", bus.mem_addr, 0);
        check("rst mem_wdata", bus.mem_wdata, 0);
        check("rst out_valE", bus.out_valE, 0);
        check("rst out_valM", bus.out_valM, 0);
        check("rst out_icode", 32'(bus.out_icode), 0);
        check("rst out_dstE", 32'(bus.out_dstE), 32'hF);
        check("rst out_dstM", 32'(bus.out_dstM), 32'hF);
        check("rst out_stat", 32'(bus.out_stat), 1);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        int   req_cycles;
        @(negedge clock);
        check($sformatf("v%0d in_ready", idx), 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_icode = v.icode;
        bus.in_Cnd   = v.cnd;
        bus.in_valE  = v.vale;
        bus.in_valA  = v.vala;
        bus.in_valP  = v.valp;
        bus.in_dstE  = v.dste;
        bus.in_dstM  = v.dstm;
        bus.in_stat  = v.stat;
        e.icode = v.icode; e.vale = v.vale; e.valm = v.x_valm;
        e.dste = v.x_dste; e.dstm = v.dstm; e.stat = v.x_stat;
        sb.push_back(e);
        @(negedge clock);
        idle_inputs();
        req_cycles = 0;
        for (int c = 0; c < 40 && !bus.out_valid; c++) begin
            bus.mem_ack = 1'b0;
            bus.mem_err = 1'b0;
            if (bus.mem_req) begin
                req_cycles++;
                check($sformatf("v%0d mem_we", idx), 32'(bus.mem_we), 32'(v.x_we));
                check($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.x_addr);
                if (v.x_we) check($sformatf("v%0d mem_wdata", idx), bus.mem_wdata, v.x_wdata);
                if (v.ack_at == req_cycles) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = v.rdata;
                    bus.mem_err   = v.err;
                end
            end
            @(negedge clock);
        end
        idle_inputs();
        check($sformatf("v%0d req cycles", idx), req_cycles, v.x_req);
        if (!bus.out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL v%0d out_valid: got 0, expected 1 within 40 cycles", idx);
            void'(sb.pop_front());
            do_reset();
            return;
        end
        e = sb.pop_front();
        for (int h = 0; h <= v.hold; h++) begin
            check($sformatf("v%0d out_valid", idx), 32'(bus.out_valid), 1);
            check($sformatf("v%0d in_ready busy", idx), 32'(bus.in_ready), 0);
            check($sformatf("v%0d out_icode", idx), 32'(bus.out_icode), 32'(e.icode));
            check($sformatf("v%0d out_valE", idx), bus.out_valE, e.vale);
            check($sformatf("v%0d out_valM", idx), bus.out_valM, e.valm);
            check($sformatf("v%0d out_dstE", idx), 32'(bus.out_dstE), 32'(e.dste));
            check($sformatf("v%0d out_dstM", idx), 32'(bus.out_dstM), 32'(e.dstm));
            check($sformatf("v%0d out_stat", idx), 32'(bus.out_stat), 32'(e.stat));
            check($sformatf("v%0d mem_req in OUT", idx), 32'(bus.mem_req), 0);
            if (h < v.hold) begin
                if (v.late_ack) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = 32'hBAD0BAD0;
                end
                @(negedge clock);
                bus.mem_ack = 1'b0;
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
        if (e.stat != 3'd1) begin
            check($sformatf("v%0d halted", idx), 32'(halted), 1);
            check($sformatf("v%0d in_ready halt", idx), 32'(bus.in_ready), 0);
            check($sformatf("v%0d out_valid halt", idx), 32'(bus.out_valid), 0);
            @(negedge clock);
            check($sformatf("v%0d mem_req halt", idx), 32'(bus.mem_req), 0);
            check($sformatf("v%0d still halted", idx), 32'(halted), 1);
            do_reset();
        end else begin
            check($sformatf("v%0d halted", idx), 32'(halted), 0);
            check($sformatf("v%0d in_ready back", idx), 32'(bus.in_ready), 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // icode cnd valE valA valP dstE dstM stat | ack rdata err hold late | req we addr wdata valM dstE stat
        vecs[0]  = mk(4'h4, 1, 32'h100, 32'hDEADBEEF, 32'h10, 4'hF, 4'hF, 1, 2, 0, 0, 0, 0,
                      2, 1, 32'h100, 32'hDEADBEEF, 0, 4'hF, 1);
        vecs[1]  = mk(4'h5, 1, 32'h20, 0, 32'h16, 4'hF, 4'h6, 1, 1, 32'h12345678, 0, 3, 0,
                      1, 0, 32'h20, 0, 32'h12345678, 4'hF, 1);
        vecs[2]  = mk(4'h8, 1, 32'h200, 7, 32'h44, 4'h4, 4'hF, 1, 1, 0, 0, 0, 0,
                      1, 1, 32'h200, 32'h44, 0, 4'h4, 1);
        vecs[3]  = mk(4'h9, 1, 32'h200, 32'h1FC, 32'h30, 4'h4, 4'hF, 1, 1, 32'h55, 0, 0, 0,
                      1, 0, 32'h1FC, 0, 32'h55, 4'h4, 1);
        vecs[4]  = mk(4'hA, 1, 32'hFFC, 32'hCAFE, 32'h31, 4'h4, 4'hF, 1, 3, 0, 0, 0, 0,
                      3, 1, 32'hFFC, 32'hCAFE, 0, 4'h4, 1);
        vecs[5]  = mk(4'hB, 1, 32'h104, 32'h100, 32'h33, 4'h4, 4'h5, 1, 1, 32'h77, 0, 1, 0,
                      1, 0, 32'h100, 0, 32'h77, 4'h4, 1);
        vecs[6]  = mk(4'h9, 1, 32'h84, 32'h80, 32'h40, 4'h4, 4'hF, 1, 16, 32'h99, 0, 0, 0,
                      16, 0, 32'h80, 0, 32'h99, 4'h4, 1);
        vecs[7]  = mk(4'h2, 0, 32'h5, 32'h5, 32'h50, 4'h3, 4'hF, 1, 0, 0, 0, 1, 0,
                      0, 0, 0, 0, 0, 4'hF, 1);
        vecs[8]  = mk(4'h2, 1, 32'h5, 32'h5, 32'h52, 4'h3, 4'hF, 1, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 4'h3, 1);
        vecs[9]  = mk(4'h3, 0, 32'h1234, 0, 32'h58, 4'h2, 4'hF, 1, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 4'h2, 1);
        vecs[10] = mk(4'h5, 1, 32'h40, 0, 32'h60, 4'hF, 4'h6, 1, 1, 32'hAAAA, 1, 0, 0,
                      1, 0, 32'h40, 0, 0, 4'hF, 3);
        vecs[11] = mk(4'hB, 1, 32'h1000, 32'hFFD, 32'h62, 4'h4, 4'h5, 1, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 4'h4, 3);
        vecs[12] = mk(4'h9, 1, 32'h84, 32'h80, 32'h64, 4'h4, 4'hF, 1, 0, 32'h99, 0, 2, 1,
                      16, 0, 32'h80, 0, 0, 4'h4, 3);
        vecs[13] = mk(4'h0, 1, 0, 0, 32'h66, 4'hF, 4'hF, 2, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 4'hF, 2);
        vecs[14] = mk(4'h5, 1, 32'h20, 0, 32'h68, 4'hF, 4'h6, 4, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 4'hF, 4);
        vecs[15] = mk(4'h4, 1, 32'hFFFFFFFE, 1, 32'h6A, 4'hF, 4'hF, 1, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 4'hF, 3);

        do_reset();
        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // Reset asserted between clock edges while a request is outstanding.
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_icode = 4'h4;
        bus.in_Cnd   = 1'b1;
        bus.in_valE  = 32'h300;
        bus.in_valA  = 32'h1;
        bus.in_stat  = 3'd1;
        @(negedge clock);
        idle_inputs();
        check("midrst mem_req before", 32'(bus.mem_req), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst mem_req async", 32'(bus.mem_req), 0);
        check("midrst in_ready async", 32'(bus.in_ready), 1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("midrst in_ready after", 32'(bus.in_ready), 1);
        check("midrst mem_req after", 32'(bus.mem_req), 0);
        check("midrst out_valid after", 32'(bus.out_valid), 0);
        run_vec(16, vecs[0]);

        check("scoreboard empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Y86 memory stage. Sits directly downstream of the execute stage and upstream of write-back.
- Takes one executed instruction at a time: its ALU result valE, valA, valP, destinations and status.
- Performs at most one 32-bit data-memory access over a req/ack port. Passes valE, valM, destinations and final status to write-back.
- Converts memory faults and timeouts into status ADR and halts the pipeline front on any non-AOK status.

Parameters:
MEM_SIZE, 4096, data memory size in bytes; legal access requires addr <= MEM_SIZE-4.
TIMEOUT, 16, maximum cycles waiting for mem_ack before the access is declared ADR.

Ports:
clock  input  1  single clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  execute offers an instruction
in_ready  output  1  stage can accept (state IDLE)
in_icode  input  4  Y86 icode
in_Cnd  input  1  condition result from execute
in_valE  input  32  ALU result
in_valA  input  32  register A value
in_valP  input  32  next PC
in_dstE  input  4  E destination register (0xF = none)
in_dstM  input  4  M destination register (0xF = none)
in_stat  input  3  incoming status: 1 AOK, 2 HLT, 3 ADR, 4 INS
out_valid  output  1  result available to write-back
out_ready  input  1  write-back consumes result
out_icode  output  4  captured icode
out_valE  output  32  captured valE
out_valM  output  32  read data (0 when no read)
out_dstE  output  4  E destination after cmov cancel
out_dstM  output  4  M destination
out_stat  output  3  final status
mem_req  output  1  access request, held until ack or timeout
mem_we  output  1  1 write, 0 read
mem_addr  output  32  byte address
mem_wdata  output  32  write data
mem_ack  input  1  access complete this cycle
mem_rdata  input  32  read data, valid with mem_ack
mem_err  input  1  access fault, valid with mem_ack
halted  output  1  stage has emitted a non-AOK status

Behaviour:
- Clock and reset: one clock (clock). reset_n is asynchronous and active-low.
- Reset values: state IDLE; in_ready 1; out_valid, mem_req, mem_we, halted 0; mem_addr, mem_wdata, out_valE, out_valM 0; out_icode 0; out_dstE, out_dstM 0xF; out_stat 1 (AOK).
- Reset asserted mid-access drops mem_req immediately and abandons the transaction.
- States: IDLE, ACCESS, OUT, HALT.
- IDLE: in_ready=1. On in_valid, capture all inputs.
  - out_dstE = (icode 2 and !Cnd) ? 0xF : in_dstE.
  - out_valM = 0.
- Access decode at capture, applied only when in_stat is AOK:
  - icode 4 rmmovl: write valA to valE.
  - icode 5 mrmovl: read valE.
  - icode 8 call: write valP to valE-aligned stack slot, i.e. mem_addr = valE.
  - icode 9 ret: read valA.
  - icode A pushl: write valA to valE.
  - icode B popl: read valA.
  - All other icodes: no access.
- Transition from IDLE on capture:
  - No access, or in_stat not AOK: go to OUT with stat unchanged.
  - Access with addr > MEM_SIZE-4: no request; stat=3; go to OUT.
  - Otherwise: go to ACCESS with mem_req=1 starting the next cycle.
- ACCESS: mem_req, mem_we, mem_addr, mem_wdata stay stable. Timeout counter starts at 0 on entry and increments each cycle without ack.
  - mem_ack seen: for a read, out_valM=mem_rdata. If mem_err, stat=3 and out_valM=0. Drop mem_req the cycle after ack; go to OUT.
  - Counter reaches TIMEOUT-1 without ack: stat=3; drop mem_req; go to OUT. A late ack is ignored.
  - Ack in the same cycle as the timeout: ack wins.
- OUT: out_valid=1 with outputs stable. On out_ready:
  - If out_stat is AOK, go to IDLE.
  - Otherwise go to HALT and set halted=1.
  - No same-cycle acceptance of a new instruction; minimum two cycles per instruction.
- HALT: in_ready=0, out_valid=0, no requests. Only reset exits.
- Address range check: 32-bit unsigned compare; wrap-around addresses near 0xFFFFFFFF are out of range.

Test Plan:
- rmmovl: in_icode=4, valE=0x100, valA=0xDEADBEEF; ack after 2 cycles -> one write to 0x100 with wdata 0xDEADBEEF; out_stat=1, out_valM=0.
- mrmovl: icode 5, valE=0x20; ack with rdata 0x12345678 -> out_valM=0x12345678, out_dstM preserved. Hold out_ready=0 for 3 cycles -> outputs stable.
- Out-of-range popl: icode B, valA=0xFFD (MEM_SIZE 4096) -> mem_req never asserts; out_stat=3; after out_ready, halted=1 and in_ready=0.
- Timeout: icode 9 ret, never ack -> mem_req high for exactly 16 cycles, then out_stat=3. A late ack afterwards has no effect.
- cmov not taken: icode 2, Cnd=0, dstE=3 -> out_dstE=0xF, no memory request. HLT instruction (in_stat=2) -> passes with stat 2, then stage halts.
- Assert reset_n low during ACCESS -> mem_req falls without a clock edge; after release, state IDLE and in_ready=1.
